data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
Word-addressed data memory that serves as the responder for the datapath memory port (Address, WriteData, ReadData).
- Accepts single-cycle read/write commands.
- Completes each command after a fixed, configurable latency and signals completion with a one-cycle ready pulse.
- Sits between the datapath/controller and storage; its handshake is the multi-cycle stand-in for a cache.

Parameters:
- NBITS, 8, data word width; also sets address width (Address spans NBITS-1:2).
- NWORDS, 2**(NBITS-2), number of implemented words; must be ≤ 2**(NBITS-2).
- LATENCY, 2, edges from command acceptance to ready; legal range ≥1.

Ports:
- clock  input  1  system clock.
- reset  input  1  reset.
- req  input  1  command strobe, single-cycle pulse from initiator.
- we  input  1  1=write, 0=read; qualified by req.
- Address  input  NBITS-2 (NBITS-1:2)  word address; qualified by req.
- WriteData  input  NBITS  write data; qualified by req.
- ReadData  output  NBITS  response data; valid while ready=1.
- ready  output  1  completion pulse, exactly one cycle per accepted command.
- busy  output  1  high while a command is outstanding (states WAIT and DONE).
- overrun  output  1  sticky: a req arrived while busy.
- mmio_out  output  NBITS  memory-mapped output register; see Optional Feature.

Behaviour:
- Reset is synchronous, active-high, on clock.
- Reset values:
  - all storage words 0;
  - ReadData 0, ready 0, busy 0, overrun 0, mmio_out 0;
  - state IDLE.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - On an edge with req=1, latch Address, we and WriteData.
  - Go to DONE if LATENCY==1; otherwise go to WAIT and load the counter with LATENCY-2.
- WAIT: count down each edge; at counter 0 go to DONE.
- DONE: ready=1 for this cycle only; next state IDLE unconditionally.
- Latency: req sampled at edge k; ready is high in the cycle following edge k+LATENCY-1, i.e. ready is observed LATENCY cycles after req.
- Write commit:
  - Storage updates on the edge that enters DONE.
  - ReadData during ready echoes the written value.
- Read:
  - ReadData equals the storage word at the latched address, captured on entry to DONE.
  - ReadData holds its value after ready drops, until the next completion.
- Commands are accepted only in IDLE.
  - A req in WAIT or DONE is ignored (no latch, no state change) and sets overrun=1.
  - overrun clears only on reset.
  - A req in the same cycle as ready is an overrun.
- Out-of-range addresses (Address ≥ NWORDS):
  - reads return 0;
  - writes are dropped;
  - the handshake completes normally and overrun is unaffected.
- Reset mid-operation: the outstanding command is aborted, no write is committed and ready is not asserted.
- Storage read is combinational from the latched address; there is no read-during-write hazard, since there is one command at a time.

Optional Feature:
- Macro: DMEM_MMIO_EN.
- Defined:
  - A write to word address NWORDS-1 also loads mmio_out with the write data, on the same commit edge.
  - Storage is still written and reads return storage.
- Undefined: mmio_out is tied to 0 and there is no extra logic.

Decomposition:
- Package dmem_pkg:
  - typedef enum dmem_state_t {IDLE, WAIT, DONE};
  - localparam DMEM_DEFAULT_LATENCY = 2.
- One sub-module: dmem_array (NWORDS×NBITS storage, sync write with enable, comb read, sync clear on reset).
- Top-level data_mem_responder holds the FSM, counter, latches, overrun and mmio_out.

Test Plan:
- Write then read, LATENCY=2:
  - req/we=1, Address=5, WriteData=0xA5 → ready pulses 2 cycles later with ReadData=0xA5.
  - Then read Address=5 → ready after 2 cycles with ReadData=0xA5; busy high between.
- LATENCY=1: read Address=0 after reset → ready the next cycle, ReadData=0x00; back-to-back command accepted the cycle after ready.
- Overrun:
  - write Address=3, 0x3C; second req during WAIT → overrun=1 and only one ready pulse;
  - a later read of Address=3 returns 0x3C;
  - overrun stays 1 until reset.
- Out-of-range, NWORDS=32:
  - write Address=40 with 0xFF → ready pulses;
  - read Address=40 → ReadData=0x00;
  - read Address=8 is unchanged.
- Reset mid-operation: write Address=7, 0x77 and assert reset during WAIT → no ready; read Address=7 afterwards returns 0x00.
- With DMEM_MMIO_EN, NWORDS=64: write Address=63, 0x5A → mmio_out=0x5A on the ready cycle; without the macro, mmio_out stays 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg -- shared types and defaults for the data memory responder.
//   dmem_state_t          : handshake FSM states (IDLE, WAIT, DONE)
//   DMEM_DEFAULT_LATENCY  : default command-to-ready latency in clock edges
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } dmem_state_t;

    localparam int DMEM_DEFAULT_LATENCY = 2;

endpackage

// File: rtl/dmem_array.sv
// dmem_array -- NWORDS x NBITS word storage.
//   clock, reset : clock, synchronous active-high clear of every word
//   we           : write enable (writes to out-of-range addresses are dropped)
//   addr         : word address (AW bits, may exceed NWORDS-1)
//   wdata        : write data
//   rdata        : combinational read of addr; 0 when addr is out of range
module dmem_array #(
    parameter int NBITS  = 8,
    parameter int NWORDS = 2**(NBITS-2),
    parameter int AW     = NBITS-2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [NBITS-1:0] wdata,
    output logic [NBITS-1:0] rdata
);

    localparam int IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    logic [NBITS-1:0] mem [NWORDS];
    logic             in_range;
    logic [IW-1:0]    idx;

    // Extra top bit so NWORDS == 2**AW still compares correctly.
    assign in_range = ({1'b0, addr} < (AW+1)'(NWORDS));
    assign idx      = addr[IW-1:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NWORDS; i++)
                mem[i] <= '0;
        end else if (we && in_range) begin
            mem[idx] <= wdata;
        end
    end

    assign rdata = in_range ? mem[idx] : '0;

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder -- word-addressed data memory behind a multi-cycle
// req/ready handshake (stand-in for a cache on the datapath memory port).
//   clock, reset : clock, synchronous active-high reset
//   req, we      : single-cycle command strobe, 1=write / 0=read
//   Address      : word address [NBITS-1:2]
//   WriteData    : write data
//   ReadData     : response data, valid with ready, held until next completion
//   ready        : one-cycle completion pulse, LATENCY cycles after req
//   busy         : a command is outstanding
//   overrun      : sticky, a req arrived while busy (cleared by reset only)
//   mmio_out     : memory-mapped output register
// Optional feature macro DMEM_MMIO_EN: writes to word NWORDS-1 also load
// mmio_out on the commit edge; when undefined mmio_out is tied to 0.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int NBITS   = 8,
    parameter int NWORDS  = 2**(NBITS-2),
    parameter int LATENCY = DMEM_DEFAULT_LATENCY
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req,
    input  logic             we,
    input  logic [NBITS-1:2] Address,
    input  logic [NBITS-1:0] WriteData,
    output logic [NBITS-1:0] ReadData,
    output logic             ready,
    output logic             busy,
    output logic             overrun,
    output logic [NBITS-1:0] mmio_out
);

    // Counter holds at most LATENCY-2.
    localparam int CW = (LATENCY > 2) ? $clog2(LATENCY-1) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'((LATENCY >= 2) ? LATENCY-2 : 0);

    dmem_state_t      state;
    logic [CW-1:0]    cnt;
    logic [NBITS-1:2] addr_q;
    logic             we_q;
    logic [NBITS-1:0] wdata_q;
    logic [NBITS-1:0] rdata_q;
    logic             overrun_q;

    logic [NBITS-1:2] cur_addr;
    logic             cur_we;
    logic [NBITS-1:0] cur_wdata;
    logic [NBITS-1:0] arr_rdata;
    logic             go_done;

    // With LATENCY==1 DONE is entered straight from IDLE, before the latches
    // hold the command, so the commit path takes the live inputs there.
    assign cur_addr  = (state == IDLE) ? Address   : addr_q;
    assign cur_we    = (state == IDLE) ? we        : we_q;
    assign cur_wdata = (state == IDLE) ? WriteData : wdata_q;

    assign go_done = ((state == IDLE) && req && (LATENCY == 1)) ||
                     ((state == WAIT) && (cnt == '0));

    dmem_array #(
        .NBITS  (NBITS),
        .NWORDS (NWORDS),
        .AW     (NBITS-2)
    ) u_array (
        .clock (clock),
        .reset (reset),
        .we    (go_done && cur_we),
        .addr  (cur_addr),
        .wdata (cur_wdata),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (req && (state != IDLE))
                overrun_q <= 1'b1;

            case (state)
                IDLE: begin
                    if (req) begin
                        addr_q  <= Address;
                        we_q    <= we;
                        wdata_q <= WriteData;
                        if (LATENCY == 1) begin
                            state <= DONE;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == '0)
                        state <= DONE;
                    else
                        cnt <= cnt - 1'b1;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase

            // Writes echo their data; reads capture storage at commit.
            if (go_done)
                rdata_q <= cur_we ? cur_wdata : arr_rdata;
        end
    end

    assign ReadData = rdata_q;
    assign ready    = (state == DONE);
    assign busy     = (state != IDLE);
    assign overrun  = overrun_q;

`ifdef DMEM_MMIO_EN
    logic [NBITS-1:0] mmio_q;

    always_ff @(posedge clock) begin
        if (reset)
            mmio_q <= '0;
        else if (go_done && cur_we && (cur_addr == (NBITS-2)'(NWORDS-1)))
            mmio_q <= cur_wdata;
    end

    assign mmio_out = mmio_q;
`else
    assign mmio_out = '0;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder -- randomized self-checking bench for
// data_mem_responder. Two instances share stimulus buses: A (LATENCY=2,
// NWORDS=32) and B (LATENCY=1, NWORDS=64). A per-instance word array,
// overrun flag and mmio value form the reference model.
module tb_data_mem_responder;

    localparam int NB    = 8;
    localparam int AW    = NB-2;
    localparam int LAT_A = 2;
    localparam int NW_A  = 32;
    localparam int LAT_B = 1;
    localparam int NW_B  = 64;

    logic          clock = 1'b0;
    logic          reset;
    logic          req_a, req_b, we;
    logic [AW-1:0] addr;
    logic [NB-1:0] wdata;
    logic [NB-1:0] rd_a, rd_b, mmio_a, mmio_b;
    logic          rdy_a, rdy_b, busy_a, busy_b, ovr_a, ovr_b;

    always #5 clock = ~clock;

    data_mem_responder #(.NBITS(NB), .NWORDS(NW_A), .LATENCY(LAT_A)) u_dut_a (
        .clock(clock), .reset(reset), .req(req_a), .we(we), .Address(addr),
        .WriteData(wdata), .ReadData(rd_a), .ready(rdy_a), .busy(busy_a),
        .overrun(ovr_a), .mmio_out(mmio_a)
    );

    data_mem_responder #(.NBITS(NB), .NWORDS(NW_B), .LATENCY(LAT_B)) u_dut_b (
        .clock(clock), .reset(reset), .req(req_b), .we(we), .Address(addr),
        .WriteData(wdata), .ReadData(rd_b), .ready(rdy_b), .busy(busy_b),
        .overrun(ovr_b), .mmio_out(mmio_b)
    );

    int checks = 0;
    int errors = 0;

    int mem_m [2][64];
    bit ovr_m [2];
    int mmio_m [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit mmio_enabled();
`ifdef DMEM_MMIO_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic clear_model();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 64; i++) mem_m[d][i] = 0;
            ovr_m[d]  = 1'b0;
            mmio_m[d] = 0;
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; req_a = 1'b0; req_b = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        clear_model();
    endtask

    task automatic set_req(input int d, input logic v);
        if (d == 0) req_a = v; else req_b = v;
    endtask

    // One command on instance d. inj holds req for a second cycle (lands in
    // WAIT on a LATENCY>=2 instance -> overrun). tail also checks the cycle
    // after ready; without it the next command can follow back-to-back.
    task automatic cmd(input int d, input bit w, input int a, input int v,
                       input bit inj, input bit tail);
        int lat, nw, exp_rd, pulses, at;
        logic [NB-1:0] rd_seen, mmio_seen;
        lat = (d == 0) ? LAT_A : LAT_B;
        nw  = (d == 0) ? NW_A  : NW_B;
        exp_rd = w ? v : ((a < nw) ? mem_m[d][a] : 0);
        pulses = 0; at = -1; rd_seen = '0; mmio_seen = '0;

        @(negedge clock);
        set_req(d, 1'b1); we = w; addr = AW'(a); wdata = NB'(v);
        for (int n = 1; n <= lat; n++) begin
            @(negedge clock);
            if (n == 1) set_req(d, inj);
            else        set_req(d, 1'b0);
            if ((d == 0) ? rdy_a : rdy_b) begin
                pulses++; at = n;
                rd_seen   = (d == 0) ? rd_a : rd_b;
                mmio_seen = (d == 0) ? mmio_a : mmio_b;
            end
            if (n < lat) chk("busy_wait", (d == 0) ? busy_a : busy_b, 1);
        end
        set_req(d, 1'b0);

        if (w && a < nw) mem_m[d][a] = v;
        if (mmio_enabled() && w && a == nw-1) mmio_m[d] = v;
        if (inj) ovr_m[d] = 1'b1;

        chk("ready_pulses", pulses, 1);
        chk("ready_latency", at, lat);
        if (!(w && a >= nw)) chk("rdata", rd_seen, exp_rd);
        chk("mmio", mmio_seen, mmio_m[d]);

        if (tail) begin
            @(negedge clock);
            chk("ready_drop", (d == 0) ? rdy_a : rdy_b, 0);
            chk("busy_drop",  (d == 0) ? busy_a : busy_b, 0);
            chk("rdata_hold", (d == 0) ? rd_a : rd_b, rd_seen);
        end
        chk("overrun", (d == 0) ? ovr_a : ovr_b, ovr_m[d]);
    endtask

    initial begin
        reset = 1'b1; req_a = 1'b0; req_b = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        @(negedge clock);
        do_reset();

        // Reset state
        chk("rst_rd_a", rd_a, 0);      chk("rst_rd_b", rd_b, 0);
        chk("rst_rdy_a", rdy_a, 0);    chk("rst_rdy_b", rdy_b, 0);
        chk("rst_busy_a", busy_a, 0);  chk("rst_busy_b", busy_b, 0);
        chk("rst_ovr_a", ovr_a, 0);    chk("rst_ovr_b", ovr_b, 0);
        chk("rst_mmio_a", mmio_a, 0);  chk("rst_mmio_b", mmio_b, 0);

        // Write then read, LATENCY=2
        cmd(0, 1, 5, 8'hA5, 0, 1);
        cmd(0, 0, 5, 0, 0, 1);

        // LATENCY=1: read after reset, then back-to-back commands
        cmd(1, 0, 0, 0, 0, 0);
        cmd(1, 1, 9, 8'h11, 0, 0);
        cmd(1, 0, 9, 0, 0, 1);

        // Overrun: second req lands in WAIT, only one ready pulse
        cmd(0, 1, 3, 8'h3C, 1, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("no_extra_ready", rdy_a, 0);
        end
        cmd(0, 0, 3, 0, 0, 1);

        // Out-of-range on A (NWORDS=32)
        cmd(0, 1, 8, 8'h88, 0, 1);
        cmd(0, 1, 40, 8'hFF, 0, 1);
        cmd(0, 0, 40, 0, 0, 1);
        cmd(0, 0, 8, 0, 0, 1);

        // Top word: loads mmio_out only when the feature is built in
        cmd(0, 1, NW_A-1, 8'h5A, 0, 1);
        cmd(1, 1, NW_B-1, 8'h5A, 0, 1);
        cmd(1, 0, NW_B-1, 0, 0, 1);

        // Reset during WAIT aborts the write and suppresses ready
        @(negedge clock);
        req_a = 1'b1; we = 1'b1; addr = AW'(7); wdata = 8'h77;
        @(negedge clock);
        req_a = 1'b0;
        chk("midop_busy", busy_a, 1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        clear_model();
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("midop_no_ready", rdy_a, 0);
        end
        chk("midop_ovr", ovr_a, 0);
        cmd(0, 0, 7, 0, 0, 1);

        // Randomized traffic on both instances
        for (int i = 0; i < 80; i++) begin
            int  d;
            bit  inj;
            d   = int'($urandom_range(0, 1));
            inj = (d == 0) && ($urandom_range(0, 9) == 0);
            cmd(d, 1'($urandom_range(0, 1)), int'($urandom_range(0, 63)),
                int'($urandom_range(0, 255)), inj, 1'($urandom_range(0, 1)));
        end

        // Sticky overrun, then cleared by reset
        cmd(0, 1, 1, 8'h42, 1, 1);
        do_reset();
        chk("ovr_cleared", ovr_a, 0);
        cmd(0, 0, 1, 0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
